// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states and
// the alignment check used at request acceptance.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_ILL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_e;

  // Wide enough to hold READ_LATENCY-1 for the legal range 1..4.
  localparam int unsigned CNT_W = 2;

  function automatic logic access_bad(input size_e size, input logic [1:0] lane);
    case (size)
      SIZE_B:  access_bad = 1'b0;
      SIZE_H:  access_bad = lane[0];
      SIZE_W:  access_bad = (lane != 2'b00);
      default: access_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: extracts and extends load data from a memory word, and
// merges store data into the addressed lane(s) of a word for read-modify-write.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted_s;
  logic [31:0] wshift_s;
  logic [31:0] mask_s;

  // Load path: shift the addressed lane down, then sign- or zero-extend.
  always_comb begin
    shifted_s = rd_word >> {lane, 3'b000};
    case (size)
      SIZE_B:  load_data = {{24{~is_unsigned & shifted_s[7]}}, shifted_s[7:0]};
      SIZE_H:  load_data = {{16{~is_unsigned & shifted_s[15]}}, shifted_s[15:0]};
      default: load_data = shifted_s;
    endcase
  end

  // Store path: replace only the addressed lane(s) of the sampled word.
  always_comb begin
    wshift_s = wdata << {lane, 3'b000};
    case (size)
      SIZE_B:  mask_s = 32'h0000_00FF << {lane, 3'b000};
      SIZE_H:  mask_s = 32'h0000_FFFF << {lane, 3'b000};
      default: mask_s = 32'hFFFF_FFFF;
    endcase
    store_word = (rd_word & ~mask_s) | (wshift_s & mask_s);
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit on a word-wide memory port. Sub-word
// stores are done as read-modify-write; all outputs come straight from flops.
module lsu
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               we_q, we_d;
  size_e              size_q, size_d;
  logic               uns_q, uns_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;
  logic               mem_wr_en_q, mem_wr_en_d;
  logic               mem_rd_en_q, mem_rd_en_d;
  logic [31:0]        mem_wr_addr_q, mem_wr_addr_d;
  logic [31:0]        mem_wr_data_q, mem_wr_data_d;
  logic [31:0]        mem_rd_addr_q, mem_rd_addr_d;

  size_e              req_size_s;
  logic               hs_s;
  logic               bad_s;
  logic [31:0]        word_addr_s;
  logic [31:0]        load_data_s;
  logic [31:0]        store_word_s;

  assign req_size_s  = size_e'(req_size);
  assign hs_s        = req_valid & req_ready_q;
  assign bad_s       = access_bad(req_size_s, req_addr[1:0]);
  assign word_addr_s = {req_addr[31:2], 2'b00};

  lsu_lane u_lane (
    .rd_word     (mem_rd_data),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data_s),
    .store_word  (store_word_s)
  );

  // State and wait-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; sub-word stores read first, word stores write directly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!hs_s) begin
          state_d = IDLE;
        end else if (bad_s) begin
          state_d = RESP;
        end else if (req_we && (req_size_s == SIZE_W)) begin
          state_d = WR;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        state_d = RD_WAIT;
        cnt_d   = CNT_W'(READ_LATENCY - 1);
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = we_q ? WR : RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and request-capture logic, computed from the upcoming state.
  always_comb begin
    req_ready_d   = (state_d == IDLE);
    mem_rd_en_d   = (state_d == RD_REQ);
    mem_wr_en_d   = (state_d == WR);
    resp_valid_d  = (state_d == RESP);
    resp_err_d    = hs_s & bad_s;
    we_d          = hs_s ? req_we : we_q;
    size_d        = hs_s ? req_size_s : size_q;
    uns_d         = hs_s ? req_unsigned : uns_q;
    lane_d        = hs_s ? req_addr[1:0] : lane_q;
    wdata_d       = hs_s ? req_wdata : wdata_q;
    if (hs_s && !bad_s) begin
      mem_rd_addr_d = word_addr_s;
      mem_wr_addr_d = word_addr_s;
    end else begin
      mem_rd_addr_d = mem_rd_addr_q;
      mem_wr_addr_d = mem_wr_addr_q;
    end
    if (state_d == WR) begin
      mem_wr_data_d = (state_q == IDLE) ? req_wdata : store_word_s;
    end else begin
      mem_wr_data_d = mem_wr_data_q;
    end
    // Only a load leaving RD_WAIT carries data; stores and errors return zero.
    if ((state_q == RD_WAIT) && (state_d == RESP)) begin
      resp_rdata_d = load_data_s;
    end else begin
      resp_rdata_d = 32'h0000_0000;
    end
  end

  // Output and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'h0000_0000;
      resp_err_q    <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_addr_q <= 32'h0000_0000;
      mem_wr_data_q <= 32'h0000_0000;
      mem_rd_addr_q <= 32'h0000_0000;
      we_q          <= 1'b0;
      size_q        <= SIZE_B;
      uns_q         <= 1'b0;
      lane_q        <= 2'b00;
      wdata_q       <= 32'h0000_0000;
    end else begin
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_rd_addr = mem_rd_addr_q;

endmodule
